// File: rtl/packetmem_nbuf.sv
// N-buffer packet memory: buffers circulate free list -> snooper -> CPU queue -> CPU
// -> forwarder queue -> forwarder -> free list, with each stage owning one buffer at a time.
module packetmem_nbuf #(
    parameter int N_BUFS     = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         sn_addr,
    input  logic [DATA_WIDTH-1:0]         sn_wr_data,
    input  logic                          sn_wr_en,
    input  logic                          sn_done,
    output logic                          sn_rdy,
    input  logic [ADDR_WIDTH-1:0]         cpu_addr,
    input  logic                          cpu_rd_en,
    output logic [DATA_WIDTH-1:0]         cpu_rd_data,
    input  logic                          cpu_acc,
    input  logic                          cpu_rej,
    output logic                          cpu_rdy,
    output logic [ADDR_WIDTH:0]           cpu_len,
    input  logic [ADDR_WIDTH-1:0]         fwd_addr,
    input  logic                          fwd_rd_en,
    output logic [DATA_WIDTH-1:0]         fwd_rd_data,
    input  logic                          fwd_done,
    output logic                          fwd_rdy,
    output logic [ADDR_WIDTH:0]           fwd_len,
    output logic [$clog2(N_BUFS+1)-1:0]   free_cnt
);

    localparam int IDX_W = $clog2(N_BUFS);
    localparam int CNT_W = $clog2(N_BUFS+1);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [LEN_W-1:0] len_t;

    typedef struct packed {
        idx_t [N_BUFS-1:0] slot;
        idx_t              head;
        cnt_t              cnt;
    } fifo_t;

    function automatic idx_t ptr_add(input idx_t p, input cnt_t k);
        int unsigned s;
        s = 32'(p) + 32'(k);
        return idx_t'(s % N_BUFS);
    endfunction

    function automatic fifo_t fifo_push(input fifo_t f, input idx_t v);
        fifo_t r;
        r = f;
        r.slot[ptr_add(f.head, f.cnt)] = v;
        r.cnt = f.cnt + cnt_t'(1);
        return r;
    endfunction

    function automatic fifo_t fifo_pop(input fifo_t f);
        fifo_t r;
        r = f;
        r.head = ptr_add(f.head, cnt_t'(1));
        r.cnt  = f.cnt - cnt_t'(1);
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] mem [N_BUFS][DEPTH];

    fifo_t free_q, free_d, cpuq_q, cpuq_d, fwdq_q, fwdq_d;
    len_t  len_q [N_BUFS];
    len_t  len_d [N_BUFS];
    logic  sn_rdy_q, sn_rdy_d, cpu_rdy_q, cpu_rdy_d, fwd_rdy_q, fwd_rdy_d;
    idx_t  sn_buf_q, sn_buf_d, cpu_buf_q, cpu_buf_d, fwd_buf_q, fwd_buf_d;
    logic [DATA_WIDTH-1:0] cpu_rd_data_q, cpu_rd_data_d, fwd_rd_data_q, fwd_rd_data_d;

    logic sn_wr_ok, sn_rel, cpu_rej_ev, cpu_acc_ev, fwd_done_ev;
    len_t wr_top, sn_len_new;

    assign sn_wr_ok    = sn_rdy_q & sn_wr_en;
    assign sn_rel      = sn_rdy_q & sn_done;
    assign cpu_rej_ev  = cpu_rdy_q & cpu_rej;
    assign cpu_acc_ev  = cpu_rdy_q & cpu_acc & ~cpu_rej;
    assign fwd_done_ev = fwd_rdy_q & fwd_done;
    assign wr_top      = {1'b0, sn_addr} + len_t'(1);

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        free_d        = free_q;
        cpuq_d        = cpuq_q;
        fwdq_d        = fwdq_q;
        len_d         = len_q;
        sn_rdy_d      = sn_rdy_q;
        sn_buf_d      = sn_buf_q;
        cpu_rdy_d     = cpu_rdy_q;
        cpu_buf_d     = cpu_buf_q;
        fwd_rdy_d     = fwd_rdy_q;
        fwd_buf_d     = fwd_buf_q;
        cpu_rd_data_d = cpu_rd_data_q;
        fwd_rd_data_d = fwd_rd_data_q;

        // A write in the same cycle as sn_done still counts toward the packet length.
        sn_len_new = len_q[sn_buf_q];
        if (sn_wr_ok && (wr_top > sn_len_new)) sn_len_new = wr_top;
        if (sn_wr_ok) len_d[sn_buf_q] = sn_len_new;

        if (sn_rel) begin
            sn_rdy_d = 1'b0;
            if (sn_len_new != '0) cpuq_d = fifo_push(cpuq_d, sn_buf_q);
        end

        // Free-list push order: CPU reject, forwarder done, empty snooper packet.
        if (cpu_rej_ev) begin
            cpu_rdy_d          = 1'b0;
            free_d             = fifo_push(free_d, cpu_buf_q);
            len_d[cpu_buf_q]   = '0;
        end else if (cpu_acc_ev) begin
            cpu_rdy_d          = 1'b0;
            fwdq_d             = fifo_push(fwdq_d, cpu_buf_q);
        end
        if (fwd_done_ev) begin
            fwd_rdy_d          = 1'b0;
            free_d             = fifo_push(free_d, fwd_buf_q);
            len_d[fwd_buf_q]   = '0;
        end
        if (sn_rel && (sn_len_new == '0)) begin
            free_d             = fifo_push(free_d, sn_buf_q);
            len_d[sn_buf_q]    = '0;
        end

        // Grants look only at registered state, so a buffer released this cycle waits a cycle.
        if (!sn_rdy_q && (free_q.cnt != '0)) begin
            sn_rdy_d = 1'b1;
            sn_buf_d = free_q.slot[free_q.head];
            free_d   = fifo_pop(free_d);
        end
        if (!cpu_rdy_q && (cpuq_q.cnt != '0)) begin
            cpu_rdy_d = 1'b1;
            cpu_buf_d = cpuq_q.slot[cpuq_q.head];
            cpuq_d    = fifo_pop(cpuq_d);
        end
        if (!fwd_rdy_q && (fwdq_q.cnt != '0)) begin
            fwd_rdy_d = 1'b1;
            fwd_buf_d = fwdq_q.slot[fwdq_q.head];
            fwdq_d    = fifo_pop(fwdq_d);
        end

        if (cpu_rd_en) cpu_rd_data_d = cpu_rdy_q ? mem[cpu_buf_q][cpu_addr] : '0;
        if (fwd_rd_en) fwd_rd_data_d = fwd_rdy_q ? mem[fwd_buf_q][fwd_addr] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BUFS; i++) begin
                free_q.slot[i] <= idx_t'(i);
                len_q[i]       <= '0;
            end
            free_q.head   <= '0;
            free_q.cnt    <= cnt_t'(N_BUFS);
            cpuq_q        <= '0;
            fwdq_q        <= '0;
            sn_rdy_q      <= 1'b0;
            sn_buf_q      <= '0;
            cpu_rdy_q     <= 1'b0;
            cpu_buf_q     <= '0;
            fwd_rdy_q     <= 1'b0;
            fwd_buf_q     <= '0;
            cpu_rd_data_q <= '0;
            fwd_rd_data_q <= '0;
        end else begin
            free_q        <= free_d;
            cpuq_q        <= cpuq_d;
            fwdq_q        <= fwdq_d;
            len_q         <= len_d;
            sn_rdy_q      <= sn_rdy_d;
            sn_buf_q      <= sn_buf_d;
            cpu_rdy_q     <= cpu_rdy_d;
            cpu_buf_q     <= cpu_buf_d;
            fwd_rdy_q     <= fwd_rdy_d;
            fwd_buf_q     <= fwd_buf_d;
            cpu_rd_data_q <= cpu_rd_data_d;
            fwd_rd_data_q <= fwd_rd_data_d;
        end
    end

    // NOTE: the packet storage is deliberately not reset; stale words above len are never meaningful.
    always_ff @(posedge clk) begin
        if (!rst && sn_wr_ok) mem[sn_buf_q][sn_addr] <= sn_wr_data;
    end

    assign sn_rdy      = sn_rdy_q;
    assign cpu_rdy     = cpu_rdy_q;
    assign fwd_rdy     = fwd_rdy_q;
    assign cpu_rd_data = cpu_rd_data_q;
    assign fwd_rd_data = fwd_rd_data_q;
    assign cpu_len     = cpu_rdy_q ? len_q[cpu_buf_q] : '0;
    assign fwd_len     = fwd_rdy_q ? len_q[fwd_buf_q] : '0;
    assign free_cnt    = free_q.cnt;

endmodule

// File: doc/packetmem_nbuf.md
PACKETMEM_NBUF -- requirements
Module: packetmem_nbuf

Interface
REQ-001 SHALL have parameter N_BUFS, default 4, number of packet buffers (legal range 3..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, word-address width of each buffer.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, snooper/CPU/forwarder word width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports sn_addr in ADDR_WIDTH, sn_wr_data in DATA_WIDTH, sn_wr_en in 1: snooper word write.
REQ-007 SHALL have ports sn_done in 1 (1-cycle pulse, packet complete) and sn_rdy out 1 (snooper owns a buffer).
REQ-008 SHALL have ports cpu_addr in ADDR_WIDTH, cpu_rd_en in 1, cpu_rd_data out DATA_WIDTH: CPU word read.
REQ-009 SHALL have ports cpu_acc in 1, cpu_rej in 1 (1-cycle pulses), cpu_rdy out 1, cpu_len out ADDR_WIDTH+1.
REQ-010 SHALL have ports fwd_addr in ADDR_WIDTH, fwd_rd_en in 1, fwd_rd_data out DATA_WIDTH: forwarder word read.
REQ-011 SHALL have ports fwd_done in 1 (1-cycle pulse), fwd_rdy out 1, fwd_len out ADDR_WIDTH+1.
REQ-012 SHALL have port free_cnt out $clog2(N_BUFS+1): buffers currently on free list.

Function
REQ-013 Each buffer SHALL be in exactly one state: FREE, SNOOP, CPUQ, CPU, FWDQ, FWD.
REQ-014 Free list, CPU queue and forwarder queue SHALL be FIFOs of buffer indices, depth N_BUFS, strictly in order.
REQ-015 sn_rdy=1 iff a buffer is SNOOP; when none is SNOOP and free list non-empty, head of free list SHALL move to SNOOP next cycle.
REQ-016 sn_wr_en with sn_rdy=1 SHALL write sn_wr_data at sn_addr of the SNOOP buffer; sn_wr_en with sn_rdy=0 SHALL be dropped.
REQ-017 Each buffer len SHALL equal max written address+1 since it left FREE (saturating at 2**ADDR_WIDTH); cleared to 0 when it returns to FREE.
REQ-018 sn_done with sn_rdy=1 and len>0 SHALL push buffer to CPU queue (CPUQ); with len=0 SHALL return it to free list tail.
REQ-019 sn_wr_en and sn_done in same cycle SHALL include that write in len before the push.
REQ-020 cpu_rdy=1 iff a buffer is CPU; when none is CPU and CPU queue non-empty, head SHALL move to CPU next cycle.
REQ-021 cpu_acc with cpu_rdy=1 SHALL push CPU buffer to forwarder queue; cpu_rej SHALL push it to free list tail; both asserted SHALL act as cpu_rej.
REQ-022 fwd_rdy=1 iff a buffer is FWD; promotion from forwarder queue head identical to REQ-020; fwd_done with fwd_rdy=1 SHALL push FWD buffer to free list tail.
REQ-023 sn_done/cpu_acc/cpu_rej/fwd_done while matching rdy=0 SHALL be ignored.
REQ-024 Multiple pushes to free list in one cycle SHALL enqueue in order cpu_rej, fwd_done, sn_done(len=0).
REQ-025 A buffer released in cycle t SHALL not be re-granted before cycle t+1; no buffer ever owned by two agents.
REQ-026 cpu_rd_data/fwd_rd_data SHALL present addressed word of owned buffer 1 cycle after rd_en; hold value when rd_en=0; reads with rdy=0 return 0.
REQ-027 cpu_len/fwd_len SHALL show owned buffer len, 0 when rdy=0.
REQ-028 Buffer contents SHALL not be cleared on release; words above len are don't-care.

Reset
REQ-029 rst=1 SHALL put all buffers FREE with free list 0..N_BUFS-1, queues empty, all lens 0.
REQ-030 During/after rst all rdy=0, read data=0, len outputs=0, free_cnt=N_BUFS; sn_rdy=1 (buffer 0) second cycle after rst deasserts; rst mid-packet discards all packets.

Verification
REQ-031 Reset, write words 0..3 (0xA0..0xA3), sn_done -> cpu_rdy=1 with cpu_len=4, cpu read addr 2 returns 0xA2 one cycle later.
REQ-032 cpu_acc -> fwd_rdy=1, fwd_len=4, fwd reads match; fwd_done -> free_cnt returns to N_BUFS-1 (snooper holds one).
REQ-033 N_BUFS=4, CPU and forwarder stalled, deliver 4 packets -> sn_rdy=0 after fourth sn_done, free_cnt=0; cpu_rej -> sn_rdy=1 next cycles.
REQ-034 cpu_acc and cpu_rej same cycle -> buffer to free list, fwd_rdy stays 0.
REQ-035 sn_done with no writes -> cpu_rdy stays 0, free_cnt unchanged net; rst asserted mid-packet -> all outputs at reset values next cycle.
